// File: rtl/page_ctrl.sv
// page_ctrl: frame-synchronous page sequencer for the VGA front end.
// Chooses the title, play-field or end page, sequences start/play/end,
// latches the end-of-game results and muxes the page pixels onto pix_data.
module page_ctrl #(
    parameter int H_VALID    = 640,
    parameter int V_VALID    = 480,
    parameter int FRAME_RATE = 60,
    parameter int END_HOLD   = 180,
    parameter int SCORE_W    = 14,
    parameter int TIME_W     = 12
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic [9:0]         screen_x,
    input  logic [9:0]         screen_y,
    input  logic               frame_start,
    input  logic               key_start,
    input  logic               game_over,
    input  logic               game_won,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [15:0]        pix_title,
    input  logic [15:0]        pix_game,
    input  logic [15:0]        pix_end,
    output logic [15:0]        pix_data,
    output logic [1:0]         page_sel,
    output logic               game_rst_n,
    output logic               game_run,
    output logic               end_won,
    output logic [SCORE_W-1:0] final_score,
    output logic [TIME_W-1:0]  game_time
);

    localparam int TICK_W = (FRAME_RATE > 1) ? $clog2(FRAME_RATE) : 1;
    localparam int HOLD_W = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_RATE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD - 1);
    localparam logic [10:0]       H_LIM     = 11'(H_VALID);
    localparam logic [10:0]       V_LIM     = 11'(V_VALID);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_PLAY,
        ST_END_HOLD,
        ST_END_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic                key_prev_q, key_prev_d;
    logic                key_pend_q, key_pend_d;
    logic                end_pend_q, end_pend_d;
    logic                won_pend_q, won_pend_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TIME_W-1:0]   game_time_q, game_time_d;
    logic [SCORE_W-1:0]  final_score_q, final_score_d;
    logic                end_won_q, end_won_d;
    logic [1:0]          page_sel_q, page_sel_d;
    logic                game_rst_n_q, game_rst_n_d;
    logic                game_run_q, game_run_d;
    logic [15:0]         pix_data_q, pix_data_d;
    logic                key_edge;
    logic                out_of_area;

    // Next-state and next-output computation for the sequencer and pixel mux.
    // Event latching is evaluated before the frame_start transition so that a
    // consume/clear at frame_start overrides a same-cycle set.
    always_comb begin
        state_d       = state_q;
        key_prev_d    = key_start;
        key_pend_d    = key_pend_q;
        end_pend_d    = end_pend_q;
        won_pend_d    = won_pend_q;
        tick_d        = tick_q;
        hold_d        = hold_q;
        game_time_d   = game_time_q;
        final_score_d = final_score_q;
        end_won_d     = end_won_q;

        key_edge = key_start & ~key_prev_q;
        if (key_edge && (state_q == ST_IDLE || state_q == ST_END_WAIT)) begin
            key_pend_d = 1'b1;
        end

        if ((state_q == ST_PLAY || (state_q == ST_START && frame_start)) &&
            (game_over || game_won)) begin
            end_pend_d = 1'b1;
            won_pend_d = end_pend_q ? (won_pend_q & ~game_over)
                                    : (game_won & ~game_over);
        end

        if (frame_start) begin
            case (state_q)
                ST_IDLE, ST_END_WAIT: begin
                    if (key_pend_q) begin
                        state_d     = ST_START;
                        key_pend_d  = 1'b0;
                        game_time_d = '0;
                        tick_d      = '0;
                    end
                end
                ST_START: begin
                    state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (game_time_q != '1) begin
                            game_time_d = game_time_q + TIME_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                    if (end_pend_q) begin
                        final_score_d = score_in;
                        end_won_d     = won_pend_q;
                        end_pend_d    = 1'b0;
                        won_pend_d    = 1'b0;
                        key_pend_d    = 1'b0;
                        hold_d        = '0;
                        state_d       = ST_END_HOLD;
                    end
                end
                ST_END_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = ST_END_WAIT;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        case (state_d)
            ST_IDLE:               page_sel_d = 2'd0;
            ST_START, ST_PLAY:     page_sel_d = 2'd1;
            default:               page_sel_d = 2'd2;
        endcase
        game_rst_n_d = (state_d != ST_START);
        game_run_d   = (state_d == ST_PLAY);

        out_of_area = ({1'b0, screen_x} >= H_LIM) || ({1'b0, screen_y} >= V_LIM);
        if (out_of_area) begin
            pix_data_d = '0;
        end else begin
            case (page_sel_q)
                2'd0:    pix_data_d = pix_title;
                2'd1:    pix_data_d = pix_game;
                2'd2:    pix_data_d = pix_end;
                default: pix_data_d = '0;
            endcase
        end
    end

    // Register all state, latched results and outputs; asynchronous reset.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            key_prev_q    <= 1'b0;
            key_pend_q    <= 1'b0;
            end_pend_q    <= 1'b0;
            won_pend_q    <= 1'b0;
            tick_q        <= '0;
            hold_q        <= '0;
            game_time_q   <= '0;
            final_score_q <= '0;
            end_won_q     <= 1'b0;
            page_sel_q    <= 2'd0;
            game_rst_n_q  <= 1'b0;
            game_run_q    <= 1'b0;
            pix_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            key_prev_q    <= key_prev_d;
            key_pend_q    <= key_pend_d;
            end_pend_q    <= end_pend_d;
            won_pend_q    <= won_pend_d;
            tick_q        <= tick_d;
            hold_q        <= hold_d;
            game_time_q   <= game_time_d;
            final_score_q <= final_score_d;
            end_won_q     <= end_won_d;
            page_sel_q    <= page_sel_d;
            game_rst_n_q  <= game_rst_n_d;
            game_run_q    <= game_run_d;
            pix_data_q    <= pix_data_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign page_sel    = page_sel_q;
    assign game_rst_n  = game_rst_n_q;
    assign game_run    = game_run_q;
    assign end_won     = end_won_q;
    assign final_score = final_score_q;
    assign game_time   = game_time_q;

endmodule
